alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX boundary producer that drives the execute-stage ALU.
- Encodes decoded RISC-V fields (opcode, funct3, funct7[5]) into the 4-bit ALU Operation code.
- Selects SrcA/SrcB from rs1, rs2, pc, imm or the constants 0/4.
- Registers the result behind a 2-entry skid buffer with valid/ready handshake and synchronous flush.

Parameters:
- DATA_WIDTH, 32, operand/immediate/pc width.
- OPCODE_LENGTH, 4, ALU Operation code width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill (branch mispredict/trap).
- in_valid  in  1  decode stage offers an instruction.
- in_ready  out  1  stage can accept; registered.
- in_opcode  in  7  instr[6:0].
- in_funct3  in  3  instr[14:12].
- in_funct7_5  in  1  instr[30].
- in_rs1  in  DATA_WIDTH  register-file read 1.
- in_rs2  in  DATA_WIDTH  register-file read 2.
- in_imm  in  DATA_WIDTH  sign-extended immediate.
- in_pc  in  DATA_WIDTH  instruction address.
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  execute stage accepts.
- SrcA  out  DATA_WIDTH  ALU operand A.
- SrcB  out  DATA_WIDTH  ALU operand B.
- Operation  out  OPCODE_LENGTH  ALU op code.
- out_rs2  out  DATA_WIDTH  store data passthrough.
- out_illegal  out  1  unsupported encoding flag.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, SrcA/SrcB/out_rs2=0, Operation=4'b0000, out_illegal=0, both entries empty.
- Encoding by opcode:
  - R-type 0110011 and I-type 0010011, by funct3:
    - 000: ADD 0010; SUB 0110 only for R-type with funct7_5=1.
    - 001: SLL 0100.
    - 010: SLT 1011.
    - 011: SLTU 1111.
    - 100: XOR 0101.
    - 101: SRL 0011, or SRA 0111 when funct7_5=1.
    - 110: OR 0001.
    - 111: AND 0000.
  - Load 0000011 / store 0100011: ADD.
  - Branch 1100011, by funct3: 000→1100, 001→1101, 100→1011, 101→1010, 110→1111, 111→1110. funct3 010/011 is illegal.
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111: ADD.
- Operand select:
  - SrcA = rs1 by default; 0 for LUI; pc for AUIPC/JAL/JALR.
  - SrcB = rs2 for R-type and branch; imm for I-type/load/store/LUI/AUIPC; 4 for JAL/JALR.
  - Shifts (R- and I-type): SrcB is masked to bits [4:0], upper bits zero.
- Illegal (any other opcode, or a bad branch funct3): entry is still issued with out_illegal=1, Operation=0000, SrcA=SrcB=0.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge.
  - Latency: 1 cycle from in accept to out_valid. Throughput: 1 per cycle.
  - Entry order is main then skid. Output always shows the main entry.
  - If out_ready=0 while main is full, one further accepted input goes to skid; in_ready drops the next cycle.
  - in_ready = skid empty.
  - On an out transfer, skid moves to main.
  - Simultaneous out transfer and in accept with skid empty: the new entry loads main. Order is preserved and nothing is lost or duplicated.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Flush:
  - Clears both entries on the clock edge; out_valid=0 and in_ready=1 the next cycle.
  - An in_valid in the flush cycle is discarded.
  - Flush has priority over all transfers.
- Reset mid-operation: all entries are dropped immediately and asynchronously.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined: adds output ports perf_issued[31:0] (count of out transfers) and perf_stall[31:0] (count of cycles with out_valid&&!out_ready). Both counters reset to 0, wrap at 2^32, and are not cleared by flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_issue_pkg:
  - alu_op_e enum (4-bit: AND, OR, ADD, SRL, SLL, XOR, SUB, SRA, GE, LT, EQ, NE, GEU, LTU).
  - RISC-V opcode localparams.
  - srca_sel_e / srcb_sel_e enums.
  - issue_entry_t struct (srca, srcb, op, rs2, illegal).
- Sub-module alu_op_encoder: purely combinational fields→{op, srca_sel, srcb_sel, illegal}. The top holds the operand muxes and skid buffer.

Test Plan:
- R-type SUB, rs1=5, rs2=7, funct7_5=1, out_ready=1 → next cycle out_valid=1, Operation=0110, SrcA=5, SrcB=7.
- SRAI, imm=0x40000403, funct7_5=1 → Operation=0111, SrcB=0x00000003.
- out_ready=0; push A, B (ADDI imm 1, 2) → in_ready=0 after B, C held on input. Raise out_ready → A, B, C delivered in order on consecutive cycles.
- Branch funct3=110 → Operation=1111, SrcB=rs2. Branch funct3=010 → out_illegal=1, Operation=0000.
- Both entries full plus in_valid=1, assert flush → next cycle out_valid=0, in_ready=1, and no entry is ever delivered.
- rst_n low mid-stream → out_valid=0 without a clock edge. With ALU_ISSUE_PERF_EN: perf_issued=0 after reset; 3 transfers and 2 stall cycles → perf_issued=3, perf_stall=2.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: ALU op codes, RISC-V opcodes,
// operand-select enums and the buffered issue entry.
package alu_issue_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SRL = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_GE  = 4'b1010,
        ALU_LT  = 4'b1011,
        ALU_EQ  = 4'b1100,
        ALU_NE  = 4'b1101,
        ALU_GEU = 4'b1110,
        ALU_LTU = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_ZERO = 2'd1,
        SRCA_PC   = 2'd2
    } srca_sel_e;

    // *_SHAMT variants zero everything above bit 4 for shift amounts
    typedef enum logic [2:0] {
        SRCB_RS2       = 3'd0,
        SRCB_IMM       = 3'd1,
        SRCB_FOUR      = 3'd2,
        SRCB_ZERO      = 3'd3,
        SRCB_RS2_SHAMT = 3'd4,
        SRCB_IMM_SHAMT = 3'd5
    } srcb_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] srca;
        logic [XLEN-1:0] srcb;
        alu_op_e         op;
        logic [XLEN-1:0] rs2;
        logic            illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_op_encoder.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU op and operand selects.
module alu_op_encoder
    import alu_issue_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_op_e    op_c,
    output srca_sel_e  srca_sel_c,
    output srcb_sel_e  srcb_sel_c,
    output logic       illegal_c
);

    // Field decode; illegal encodings are forced to AND with zero operands at the end
    always_comb begin
        op_c       = ALU_ADD;
        srca_sel_c = SRCA_RS1;
        srcb_sel_c = SRCB_RS2;
        illegal_c  = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_IMM: begin
                srcb_sel_c = (opcode == OPC_OP) ? SRCB_RS2 : SRCB_IMM;
                case (funct3)
                    3'b000:  op_c = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  op_c = ALU_SLL;
                    3'b010:  op_c = ALU_LT;
                    3'b011:  op_c = ALU_LTU;
                    3'b100:  op_c = ALU_XOR;
                    3'b101:  op_c = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  op_c = ALU_OR;
                    default: op_c = ALU_AND;
                endcase
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    srcb_sel_c = (opcode == OPC_OP) ? SRCB_RS2_SHAMT : SRCB_IMM_SHAMT;
                end
            end
            OPC_LOAD, OPC_STORE: begin
                srcb_sel_c = SRCB_IMM;
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  op_c = ALU_EQ;
                    3'b001:  op_c = ALU_NE;
                    3'b100:  op_c = ALU_LT;
                    3'b101:  op_c = ALU_GE;
                    3'b110:  op_c = ALU_LTU;
                    3'b111:  op_c = ALU_GEU;
                    default: illegal_c = 1'b1;
                endcase
            end
            OPC_LUI: begin
                srca_sel_c = SRCA_ZERO;
                srcb_sel_c = SRCB_IMM;
            end
            OPC_AUIPC: begin
                srca_sel_c = SRCA_PC;
                srcb_sel_c = SRCB_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                srca_sel_c = SRCA_PC;
                srcb_sel_c = SRCB_FOUR;
            end
            default: illegal_c = 1'b1;
        endcase
        if (illegal_c) begin
            op_c       = ALU_AND;
            srca_sel_c = SRCA_ZERO;
            srcb_sel_c = SRCB_ZERO;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: encodes ALU op, muxes operands and holds results in a
// two-entry (main + skid) buffer with valid/ready and synchronous flush.
// Optional performance counters are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic                     in_funct7_5,
    input  logic [DATA_WIDTH-1:0]    in_rs1,
    input  logic [DATA_WIDTH-1:0]    in_rs2,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    out_rs2,
    output logic                     out_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_stall
`endif
);

    alu_op_e      enc_op;
    srca_sel_e    enc_srca_sel;
    srcb_sel_e    enc_srcb_sel;
    logic         enc_illegal;
    issue_entry_t new_entry;

    issue_entry_t main_q, main_d;
    issue_entry_t skid_q, skid_d;
    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic         in_fire;
    logic         out_fire;

    alu_op_encoder u_enc (
        .opcode     (in_opcode),
        .funct3     (in_funct3),
        .funct7_5   (in_funct7_5),
        .op_c       (enc_op),
        .srca_sel_c (enc_srca_sel),
        .srcb_sel_c (enc_srcb_sel),
        .illegal_c  (enc_illegal)
    );

    // Operand muxes building the entry offered this cycle
    always_comb begin
        new_entry         = '0;
        new_entry.op      = enc_op;
        new_entry.rs2     = XLEN'(in_rs2);
        new_entry.illegal = enc_illegal;
        case (enc_srca_sel)
            SRCA_RS1: new_entry.srca = XLEN'(in_rs1);
            SRCA_PC:  new_entry.srca = XLEN'(in_pc);
            default:  new_entry.srca = '0;
        endcase
        case (enc_srcb_sel)
            SRCB_RS2:       new_entry.srcb = XLEN'(in_rs2);
            SRCB_IMM:       new_entry.srcb = XLEN'(in_imm);
            SRCB_FOUR:      new_entry.srcb = XLEN'(4);
            SRCB_RS2_SHAMT: new_entry.srcb = XLEN'(in_rs2[4:0]);
            SRCB_IMM_SHAMT: new_entry.srcb = XLEN'(in_imm[4:0]);
            default:        new_entry.srcb = '0;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_v_q && out_ready;

    // Main/skid next state; flush wins, skid refills main on an output transfer
    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (out_fire) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = in_fire;
                if (in_fire) begin
                    main_d = new_entry;
                end
            end
        end else if (in_fire) begin
            if (!main_v_q) begin
                main_d   = new_entry;
                main_v_d = 1'b1;
            end else begin
                skid_d   = new_entry;
                skid_v_d = 1'b1;
            end
        end
    end

    // Buffer registers; in_ready tracks an empty skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            in_ready <= !skid_v_d;
        end
    end

    assign out_valid   = main_v_q;
    assign SrcA        = DATA_WIDTH'(main_q.srca);
    assign SrcB        = DATA_WIDTH'(main_q.srcb);
    assign Operation   = OPCODE_LENGTH'(main_q.op);
    assign out_rs2     = DATA_WIDTH'(main_q.rs2);
    assign out_illegal = main_q.illegal;

`ifdef ALU_ISSUE_PERF_EN
    // Free-running issue and back-pressure counters, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (out_fire && !flush) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (main_v_q && !out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] rs2;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
    } vec_t;

    // Spec tables: ALU code per funct3 for arithmetic, and per funct3 for branches (5'h10 = illegal)
    localparam logic [3:0] ARITH [8] = '{4'b0010, 4'b0100, 4'b1011, 4'b1111,
                                         4'b0101, 4'b0011, 4'b0001, 4'b0000};
    localparam logic [4:0] BRTAB [8] = '{5'h0C, 5'h0D, 5'h10, 5'h10,
                                         5'h0B, 5'h0A, 5'h0F, 5'h0E};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_funct7_5 = 1'b0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic [31:0] out_rs2;
    logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
    logic [31:0] m_issued = '0;
    logic [31:0] m_stall = '0;
`endif

    int n_chk = 0;
    int n_pass = 0;
    exp_t q[$];

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7_5 (in_funct7_5),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Operation   (Operation),
        .out_rs2     (out_rs2),
        .out_illegal (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    // Expected ALU inputs straight from the instruction-set rules
    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic [4:0] br;
        e.rs2 = v.rs2;
        e.ill = 1'b0;
        e.op  = 4'b0010;
        e.a   = v.rs1;
        e.b   = v.rs2;
        if (v.opc == 7'b0110011 || v.opc == 7'b0010011) begin
            e.op = ARITH[v.f3];
            if (v.opc == 7'b0010011) e.b = v.imm;
            if (v.f3 == 3'd0 && v.f7 && v.opc == 7'b0110011) e.op = 4'b0110;
            if (v.f3 == 3'd5 && v.f7) e.op = 4'b0111;
            if (v.f3 == 3'd1 || v.f3 == 3'd5) e.b = e.b & 32'h1F;
        end else if (v.opc == 7'b0000011 || v.opc == 7'b0100011) begin
            e.b = v.imm;
        end else if (v.opc == 7'b1100011) begin
            br = BRTAB[v.f3];
            e.op  = br[3:0];
            e.ill = br[4];
        end else if (v.opc == 7'b0110111) begin
            e.a = 32'd0;
            e.b = v.imm;
        end else if (v.opc == 7'b0010111) begin
            e.a = v.pc;
            e.b = v.imm;
        end else if (v.opc == 7'b1101111 || v.opc == 7'b1100111) begin
            e.a = v.pc;
            e.b = 32'd4;
        end else begin
            e.ill = 1'b1;
        end
        if (e.ill) begin
            e.op = 4'b0000;
            e.a  = 32'd0;
            e.b  = 32'd0;
        end
        return e;
    endfunction

    // Reference queue: capacity 2, pop then push each edge, flush empties it
    always @(posedge clk or negedge rst_n) begin
        vec_t v;
        int   sz;
        if (!rst_n) begin
            q.delete();
`ifdef ALU_ISSUE_PERF_EN
            m_issued = '0;
            m_stall  = '0;
`endif
        end else begin
            sz = q.size();
`ifdef ALU_ISSUE_PERF_EN
            if (sz > 0 && out_ready && !flush) m_issued = m_issued + 32'd1;
            if (sz > 0 && !out_ready) m_stall = m_stall + 32'd1;
`endif
            if (flush) begin
                q.delete();
            end else begin
                if (sz > 0 && out_ready) void'(q.pop_front());
                if (in_valid && sz < 2) begin
                    v = '{in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm, in_pc};
                    q.push_back(model(v));
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the reference queue
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("SrcA", SrcA, q[0].a);
                chk("SrcB", SrcB, q[0].b);
                chk("Operation", 32'(Operation), 32'(q[0].op));
                chk("out_rs2", out_rs2, q[0].rs2);
                chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
            end
`ifdef ALU_ISSUE_PERF_EN
            chk("perf_issued", perf_issued, m_issued);
            chk("perf_stall", perf_stall, m_stall);
`endif
        end
    end

    task automatic drive(input logic v, input vec_t x);
        in_valid    = v;
        in_opcode   = x.opc;
        in_funct3   = x.f3;
        in_funct7_5 = x.f7;
        in_rs1      = x.rs1;
        in_rs2      = x.rs2;
        in_imm      = x.imm;
        in_pc       = x.pc;
    endtask

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc);
        vec_t x;
        x = '{opc, f3, f7, rs1, rs2, imm, pc};
        return x;
    endfunction

    vec_t idle;
    vec_t stream [22];

    initial begin
        int cyc;
        int tries;
        logic rdy;
        idle = mk(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        stream = '{
            mk(7'b0110111, 3'd0, 1'b0, 32'h11, 32'h22, 32'hABCDE000, 32'h100),
            mk(7'b0010111, 3'd0, 1'b0, 32'h11, 32'h22, 32'h00001000, 32'h104),
            mk(7'b1101111, 3'd0, 1'b0, 32'h11, 32'h22, 32'h00000800, 32'h108),
            mk(7'b1100111, 3'd0, 1'b0, 32'h11, 32'h22, 32'h00000010, 32'h10C),
            mk(7'b0000011, 3'd2, 1'b0, 32'h2000, 32'h5, 32'hFFFFFFFC, 32'h110),
            mk(7'b0100011, 3'd2, 1'b0, 32'h2000, 32'hDEAD, 32'h8, 32'h114),
            mk(7'b0110011, 3'd3, 1'b0, 32'h1, 32'h2, 32'h0, 32'h118),
            mk(7'b0010011, 3'd2, 1'b0, 32'h7, 32'h0, 32'hFFFFFFFF, 32'h11C),
            mk(7'b0110011, 3'd4, 1'b0, 32'hF0F0, 32'h0FF0, 32'h0, 32'h120),
            mk(7'b0110011, 3'd6, 1'b0, 32'hF0F0, 32'h0FF0, 32'h0, 32'h124),
            mk(7'b0110011, 3'd7, 1'b0, 32'hF0F0, 32'h0FF0, 32'h0, 32'h128),
            mk(7'b0110011, 3'd1, 1'b1, 32'h1, 32'hFFFFFFE3, 32'h0, 32'h12C),
            mk(7'b0010011, 3'd5, 1'b0, 32'h80000000, 32'h0, 32'h0000003F, 32'h130),
            mk(7'b0010011, 3'd0, 1'b1, 32'h3, 32'h9, 32'h40000000, 32'h134),
            mk(7'b1100011, 3'd0, 1'b0, 32'h3, 32'h3, 32'h0, 32'h138),
            mk(7'b1100011, 3'd1, 1'b0, 32'h3, 32'h4, 32'h0, 32'h13C),
            mk(7'b1100011, 3'd4, 1'b0, 32'h3, 32'h4, 32'h0, 32'h140),
            mk(7'b1100011, 3'd5, 1'b0, 32'h3, 32'h4, 32'h0, 32'h144),
            mk(7'b1100011, 3'd7, 1'b0, 32'h3, 32'h4, 32'h0, 32'h148),
            mk(7'b1100011, 3'd3, 1'b0, 32'h3, 32'h4, 32'h0, 32'h14C),
            mk(7'b1111111, 3'd0, 1'b0, 32'h3, 32'h4, 32'h5, 32'h150),
            mk(7'b0110011, 3'd0, 1'b0, 32'h3, 32'h4, 32'h0, 32'h154)
        };

        // Reset values
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst SrcA", SrcA, 32'd0);
        chk("rst SrcB", SrcB, 32'd0);
        chk("rst Operation", 32'(Operation), 32'd0);
        chk("rst out_rs2", out_rs2, 32'd0);
        chk("rst out_illegal", 32'(out_illegal), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        chk("rst perf_issued", perf_issued, 32'd0);
`endif

        // SUB then SRAI back to back
        drive(1'b1, mk(7'b0110011, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0));
        @(negedge clk);
        chk("sub valid", 32'(out_valid), 32'd1);
        chk("sub Operation", 32'(Operation), 32'b0110);
        chk("sub SrcA", SrcA, 32'd5);
        chk("sub SrcB", SrcB, 32'd7);
        drive(1'b1, mk(7'b0010011, 3'd5, 1'b1, 32'h1234, 32'd0, 32'h40000403, 32'd0));
        @(negedge clk);
        chk("srai Operation", 32'(Operation), 32'b0111);
        chk("srai SrcB", SrcB, 32'h00000003);
        chk("srai SrcA", SrcA, 32'h1234);
        drive(1'b0, idle);
        @(negedge clk);

        // Back-pressure: A, B fill both entries, C waits
        out_ready = 1'b0;
        drive(1'b1, mk(7'b0010011, 3'd0, 1'b0, 32'd10, 32'd0, 32'd1, 32'd0));
        @(negedge clk);
        chk("bp ready after A", 32'(in_ready), 32'd1);
        drive(1'b1, mk(7'b0010011, 3'd0, 1'b0, 32'd10, 32'd0, 32'd2, 32'd0));
        @(negedge clk);
        chk("bp ready after B", 32'(in_ready), 32'd0);
        chk("bp head A", SrcB, 32'd1);
        drive(1'b1, mk(7'b0010011, 3'd0, 1'b0, 32'd10, 32'd0, 32'd3, 32'd0));
        @(negedge clk);
        chk("bp hold A", SrcB, 32'd1);
        chk("bp hold ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp deliver B", SrcB, 32'd2);
        chk("bp B sum", SrcA + SrcB, 32'd12);
        @(negedge clk);
        chk("bp deliver C", SrcB, 32'd3);
        drive(1'b0, idle);
        @(negedge clk);
        chk("bp drained", 32'(out_valid), 32'd0);

        // Branch legal and illegal funct3
        drive(1'b1, mk(7'b1100011, 3'd6, 1'b0, 32'd3, 32'd9, 32'h55, 32'h40));
        @(negedge clk);
        chk("bltu Operation", 32'(Operation), 32'b1111);
        chk("bltu SrcB", SrcB, 32'd9);
        drive(1'b1, mk(7'b1100011, 3'd2, 1'b0, 32'd3, 32'd9, 32'h55, 32'h40));
        @(negedge clk);
        chk("bad br illegal", 32'(out_illegal), 32'd1);
        chk("bad br Operation", 32'(Operation), 32'd0);
        drive(1'b0, idle);
        @(negedge clk);

        // Mixed stream under irregular back-pressure
        cyc = 0;
        for (int i = 0; i < 22; i++) begin
            tries = 0;
            do begin
                drive(1'b1, stream[i]);
                out_ready = (cyc % 3 != 2);
                rdy = in_ready;
                cyc++;
                tries++;
                @(negedge clk);
            end while (!rdy && tries < 20);
            if (!rdy) chk("stream accept timeout", 32'd0, 32'd1);
        end
        drive(1'b0, idle);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Flush with both entries full and a new input offered
        out_ready = 1'b0;
        drive(1'b1, mk(7'b0010011, 3'd0, 1'b0, 32'd1, 32'd0, 32'd100, 32'd0));
        @(negedge clk);
        drive(1'b1, mk(7'b0010011, 3'd0, 1'b0, 32'd1, 32'd0, 32'd101, 32'd0));
        @(negedge clk);
        drive(1'b1, mk(7'b0010011, 3'd0, 1'b0, 32'd1, 32'd0, 32'd102, 32'd0));
        flush = 1'b1;
        @(negedge clk);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        drive(1'b0, idle);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post flush empty", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(1'b1, mk(7'b0110011, 3'd0, 1'b0, 32'd8, 32'd9, 32'd0, 32'd0));
        @(negedge clk);
        drive(1'b1, mk(7'b0110011, 3'd4, 1'b0, 32'd8, 32'd9, 32'd0, 32'd0));
        @(negedge clk);
        drive(1'b0, idle);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
`ifdef ALU_ISSUE_PERF_EN
        chk("async rst perf_issued", perf_issued, 32'd0);
        chk("async rst perf_stall", perf_stall, 32'd0);
`endif
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
